// File: rtl/mm_pkg.sv
// Shared multimeter types and helpers: result selection, report FSM states,
// line tags and BCD-to-ASCII mapping.
package mm_pkg;

  typedef enum logic [1:0] {
    VADC = 2'd0,
    VAVG = 2'd1,
    VRMS = 2'd2,
    VIIR = 2'd3
  } result_sel_t;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_TAG,
    RPT_DIGIT,
    RPT_EOL
  } rpt_state_t;

  localparam logic [7:0] TAG_VADC = 8'h41;  // 'A'
  localparam logic [7:0] TAG_VAVG = 8'h4D;  // 'M'
  localparam logic [7:0] TAG_VRMS = 8'h52;  // 'R'
  localparam logic [7:0] TAG_VIIR = 8'h46;  // 'F'

  // 0-9 -> '0'..'9', 0xF -> CR, anything else -> '?'
  function automatic logic [7:0] num2ascii(input logic [3:0] n);
    logic [7:0] c;
    if (n <= 4'd9)      c = 8'h30 + {4'h0, n};
    else if (n == 4'hF) c = 8'h0D;
    else                c = 8'h3F;
    return c;
  endfunction

  function automatic logic [7:0] result_tag(input result_sel_t s);
    logic [7:0] t;
    t = TAG_VADC;
    case (s)
      VADC: t = TAG_VADC;
      VAVG: t = TAG_VAVG;
      VRMS: t = TAG_VRMS;
      VIIR: t = TAG_VIIR;
      default: t = TAG_VADC;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mm_tick_gen.sv
// Free-running period counter with enable and synchronous clear; emits a
// single-cycle tick on the last count of each period.
module mm_tick_gen #(
  parameter int PERIOD_CYC = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (en) begin
      if (cnt == LAST)      cnt <= '0;
      else                  cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/mm_uart_reporter.sv
// Periodic report sequencer: snapshots the selected BCD result on each tick
// and streams "<tag><digits MSB first><CR>" over a valid/ready byte port.
module mm_uart_reporter
  import mm_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int PERIOD_CYC = 10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_en,
  input  logic [1:0]        res_sel,
  input  logic [4*NDIG-1:0] v_adc,
  input  logic [4*NDIG-1:0] v_avg,
  input  logic [4*NDIG-1:0] v_rms,
  input  logic [4*NDIG-1:0] v_iir,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  rpt_state_t              state, state_nxt;
  result_sel_t             snap_sel, sel_nxt;
  logic [NDIG-1:0][3:0]    snap_val, val_nxt, pick;
  logic [IW-1:0]           idx, idx_nxt;
  logic [7:0]              data_nxt;
  logic                    pending, take, tick;

  mm_tick_gen #(.PERIOD_CYC(PERIOD_CYC)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (uart_en),
    .clr   (!uart_en),
    .tick  (tick)
  );

  always_comb begin
    pick = v_adc;
    case (result_sel_t'(res_sel))
      VADC: pick = v_adc;
      VAVG: pick = v_avg;
      VRMS: pick = v_rms;
      VIIR: pick = v_iir;
      default: pick = v_adc;
    endcase
  end

  // A tick coinciding with the IDLE launch refills pending rather than overrunning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (!uart_en) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= tick && pending && !take;
      if (tick)      pending <= 1'b1;
      else if (take) pending <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = snap_sel;
    val_nxt   = snap_val;
    idx_nxt   = idx;
    take      = 1'b0;
    case (state)
      RPT_IDLE: if (pending && uart_en) begin
        take      = 1'b1;
        sel_nxt   = result_sel_t'(res_sel);
        val_nxt   = pick;
        idx_nxt   = IW'(NDIG - 1);
        state_nxt = RPT_TAG;
      end
      RPT_TAG: if (tx_ready) state_nxt = RPT_DIGIT;
      RPT_DIGIT: if (tx_ready) begin
        if (idx == '0) state_nxt = RPT_EOL;
        else           idx_nxt   = idx - IW'(1);
      end
      RPT_EOL: if (tx_ready) state_nxt = RPT_IDLE;
      default: state_nxt = RPT_IDLE;
    endcase

    // Output byte is decoded from the next state so tx_data/tx_valid can be registered.
    data_nxt = 8'h00;
    case (state_nxt)
      RPT_TAG:   data_nxt = result_tag(sel_nxt);
      RPT_DIGIT: data_nxt = num2ascii(val_nxt[idx_nxt]);
      RPT_EOL:   data_nxt = num2ascii(4'hF);
      default:   data_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RPT_IDLE;
      snap_sel <= VADC;
      snap_val <= '0;
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      snap_sel <= sel_nxt;
      snap_val <= val_nxt;
      idx      <= idx_nxt;
      tx_data  <= data_nxt;
      tx_valid <= (state_nxt != RPT_IDLE);
    end
  end

  assign busy = (state != RPT_IDLE);

endmodule

// File: tb/tb_mm_uart_reporter.sv
// Directed bench for mm_uart_reporter: a queue-of-bytes line model checked
// every cycle, plus literal expectations on stream contents and timing.
module tb_mm_uart_reporter;

  localparam int NDIG = 4;
  localparam int PER  = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_en;
  logic [1:0]  res_sel;
  logic [15:0] v_adc, v_avg, v_rms, v_iir;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, busy, overrun;

  mm_uart_reporter #(.NDIG(NDIG), .PERIOD_CYC(PER)) dut (
    .clk(clk), .rst_n(rst_n), .uart_en(uart_en), .res_sel(res_sel),
    .v_adc(v_adc), .v_avg(v_avg), .v_rms(v_rms), .v_iir(v_iir),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ovr_seen;
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];

  // model: bytes of the line still to be sent, head is on the wire
  int         m_cnt;
  bit         m_pend, m_ovr;
  logic [7:0] m_line[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pend = 0; m_ovr = 0;
    m_line.delete();
  endtask

  task automatic build_line(input logic [1:0] sel, input logic [15:0] v);
    logic [3:0] d;
    case (sel)
      2'd0: m_line.push_back(8'h41);
      2'd1: m_line.push_back(8'h4D);
      2'd2: m_line.push_back(8'h52);
      default: m_line.push_back(8'h46);
    endcase
    for (int i = NDIG - 1; i >= 0; i--) begin
      d = v[4*i +: 4];
      if (d < 4'd10)       m_line.push_back(8'h30 + {4'h0, d});
      else if (d == 4'hF)  m_line.push_back(8'h0D);
      else                 m_line.push_back(8'h3F);
    end
    m_line.push_back(8'h0D);
  endtask

  task automatic model_step();
    bit idle, take, tk;
    logic [15:0] v;
    idle = (m_line.size() == 0);
    take = idle && m_pend && uart_en;
    if (!idle && tx_ready) void'(m_line.pop_front());
    if (take) begin
      case (res_sel)
        2'd0: v = v_adc;
        2'd1: v = v_avg;
        2'd2: v = v_rms;
        default: v = v_iir;
      endcase
      build_line(res_sel, v);
      m_pend = 0;
    end
    m_ovr = 0;
    if (!uart_en) begin
      m_cnt = 0; m_pend = 0;
    end else begin
      tk = (m_cnt == PER - 1);
      m_cnt = tk ? 0 : m_cnt + 1;
      if (tk) begin
        if (m_pend) m_ovr = 1;
        m_pend = 1;
      end
    end
  endtask

  task automatic compare();
    bit mv;
    mv = (m_line.size() > 0);
    check("tx_valid", 32'(tx_valid), 32'(mv));
    check("busy", 32'(busy), 32'(mv));
    check("overrun", 32'(overrun), 32'(m_ovr));
    if (mv) check("tx_data", 32'(tx_data), 32'(m_line[0]));
  endtask

  // one clock: inputs are stable here, halfway between active edges
  task automatic cyc();
    if (tx_valid && tx_ready) log_q.push_back(tx_data);
    if (overrun) ovr_seen++;
    if (!rst_n) model_reset(); else model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!tx_valid && n < 200) begin cyc(); n++; end
    check("wait_valid_timeout", 32'(tx_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_valid && n < 200) begin cyc(); n++; end
    check("wait_idle_timeout", 32'(tx_valid), 32'd0);
  endtask

  task automatic check_log(input string nm);
    check({nm, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check(nm, 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  task automatic quiesce();
    uart_en = 1'b0; tx_ready = 1'b1;
    wait_idle();
    repeat (2) cyc();
    log_q.delete();
    ovr_seen = 0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; uart_en = 1'b0; res_sel = 2'd0; tx_ready = 1'b0;
    v_adc = '0; v_avg = '0; v_rms = '0; v_iir = '0;
    ovr_seen = 0;
    model_reset();
    #1;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc();

    // basic line, full-speed sink
    res_sel = 2'd1; v_avg = 16'h1234; tx_ready = 1'b1; uart_en = 1'b1;
    wait_valid(n);
    check("first_tag_latency", 32'(n), 32'd21);
    check("first_tag", 32'(tx_data), 32'h4D);
    repeat (6) cyc();
    check("after_line_valid", 32'(tx_valid), 32'd0);
    exp_q = '{8'h4D, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D};
    check_log("line_vavg");
    quiesce();

    // backpressure while '2' is on the wire
    uart_en = 1'b1;
    wait_valid(n);
    repeat (2) cyc();
    check("bp_present", 32'(tx_data), 32'h32);
    tx_ready = 1'b0;
    repeat (5) begin
      cyc();
      check("bp_hold_data", 32'(tx_data), 32'h32);
      check("bp_hold_valid", 32'(tx_valid), 32'd1);
    end
    tx_ready = 1'b1;
    cyc();
    check("bp_resume", 32'(tx_data), 32'h33);
    wait_idle();
    check_log("line_bp");
    quiesce();

    // snapshot isolation from mid-line input changes
    res_sel = 2'd2; v_rms = 16'h0987; v_iir = 16'h2468; uart_en = 1'b1;
    wait_valid(n);
    res_sel = 2'd3; v_rms = 16'hFFFF;
    wait_idle();
    wait_valid(n);
    check("next_tag_viir", 32'(tx_data), 32'h46);
    wait_idle();
    exp_q = '{8'h52, 8'h30, 8'h39, 8'h38, 8'h37, 8'h0D,
              8'h46, 8'h32, 8'h34, 8'h36, 8'h38, 8'h0D};
    check_log("line_snap");
    quiesce();

    // disable after the tag has been accepted
    res_sel = 2'd0; v_adc = 16'h0420; uart_en = 1'b1;
    wait_valid(n);
    cyc();
    uart_en = 1'b0;
    wait_idle();
    repeat (30) cyc();
    exp_q = '{8'h41, 8'h30, 8'h34, 8'h32, 8'h30, 8'h0D};
    check_log("line_disable");
    uart_en = 1'b1;
    wait_valid(n);
    check("reenable_latency", 32'(n), 32'd21);
    quiesce();

    // overrun under long stall, plus invalid/F digits
    res_sel = 2'd0; v_adc = 16'h1A0F; tx_ready = 1'b0; uart_en = 1'b1;
    wait_valid(n);
    repeat (45) cyc();
    check("stall_tag", 32'(tx_data), 32'h41);
    tx_ready = 1'b1;
    wait_idle();
    wait_valid(n);
    uart_en = 1'b0;
    wait_idle();
    repeat (30) cyc();
    exp_q = '{8'h41, 8'h31, 8'h3F, 8'h30, 8'h0D, 8'h0D,
              8'h41, 8'h31, 8'h3F, 8'h30, 8'h0D, 8'h0D};
    check_log("line_overrun");
    check("overrun_pulses", 32'(ovr_seen), 32'd1);
    quiesce();

    // asynchronous reset in the middle of a line
    res_sel = 2'd1; uart_en = 1'b1;
    wait_valid(n);
    repeat (2) cyc();
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(tx_valid), 32'd0);
    check("arst_data", 32'(tx_data), 32'h00);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    model_reset();
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
    repeat (25) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
